// File: rtl/dcache_port_arb.sv
// dcache_port_arb
//   Shares one dcache request port among NREQ in-order requesters.
//   Round-robin grant; a grant that the dcache does not accept is locked
//   until accepted. Each accepted requester ID is queued in an in-order FIFO
//   so that m_data_ok/m_rdata can be steered back to the right requester.
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_i/we_i/addr_i/wstrb_i/wdata_i   per-requester request (flat, i at [i*W+:W])
//   addr_ok_o, data_ok_o    per-requester accept / response strobes
//   rdata_o                 response data, broadcast
//   m_req_o..m_wdata_o      granted request towards the dcache
//   m_addr_ok_i, m_data_ok_i, m_rdata_i   dcache handshake
//   outstanding_o           accepted-but-unanswered count (0..DEPTH)
//   err_unexp_o             sticky: response arrived with nothing outstanding
module dcache_port_arb #(
  parameter int NREQ   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          we_i,
  input  logic [NREQ*32-1:0]       addr_i,
  input  logic [NREQ*4-1:0]        wstrb_i,
  input  logic [NREQ*DATA_W-1:0]   wdata_i,
  output logic [NREQ-1:0]          addr_ok_o,
  output logic [NREQ-1:0]          data_ok_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     m_req_o,
  output logic                     m_we_o,
  output logic [31:0]              m_addr_o,
  output logic [3:0]               m_wstrb_o,
  output logic [DATA_W-1:0]        m_wdata_o,
  input  logic                     m_addr_ok_i,
  input  logic                     m_data_ok_i,
  input  logic [DATA_W-1:0]        m_rdata_i,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_unexp_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic                      lock_valid_q, lock_valid_d;
  logic [IW-1:0]             lock_id_q, lock_id_d;
  logic [DEPTH-1:0][IW-1:0]  fifo_q;
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      err_q, err_d;

  logic [IW-1:0] gnt;
  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          accept, pop, full;

  // Grant: locked ID wins; otherwise scan upward from rr_ptr, wrapping mod NREQ.
  always_comb begin
    gnt   = lock_id_q;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    if (!lock_valid_q) begin
      gnt = rr_ptr_q;
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        cand = sum[IW-1:0];
        if (!found && req_i[cand]) begin
          gnt   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign full    = (count_q == CW'(DEPTH));
  assign m_req_o = (|req_i) && !full;
  assign accept  = m_req_o && m_addr_ok_i;
  assign pop     = m_data_ok_i && (count_q != '0);

  always_comb begin
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wstrb_o = '0;
    m_wdata_o = '0;
    addr_ok_o = '0;
    data_ok_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IW'(i)) begin
        m_we_o    = we_i[i];
        m_addr_o  = addr_i[i*32 +: 32];
        m_wstrb_o = wstrb_i[i*4 +: 4];
        m_wdata_o = wdata_i[i*DATA_W +: DATA_W];
        addr_ok_o[i] = accept;
      end
      if (fifo_q[head_q] == IW'(i)) data_ok_o[i] = pop;
    end
  end

  assign rdata_o       = m_rdata_i;
  assign outstanding_o = count_q;
  assign err_unexp_o   = err_q;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_d        = err_q;
    if (accept) begin
      rr_ptr_d     = (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
      lock_valid_d = 1'b0;
      tail_d       = tail_q + 1'b1;
    end else if (m_req_o) begin
      // dcache stalled: pin this grant so the request cannot be overtaken
      lock_valid_d = 1'b1;
      lock_id_d    = gnt;
    end
    if (pop) head_d = head_q + 1'b1;
    if (m_data_ok_i && count_q == '0) err_d = 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept) fifo_q[tail_q] <= gnt;
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
module tb_dcache_port_arb;
  localparam int NREQ = 2;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  req = '0, we = '0;
  logic [63:0] addr = '0;
  logic [7:0]  wstrb = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  addr_ok, data_ok;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata = '0;
  logic        m_req, m_we, m_addr_ok = 1'b0, m_data_ok = 1'b0, err;
  logic [3:0]  m_wstrb;
  logic [2:0]  outstanding;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int r_q[$];
  int r_rr, r_lid;
  bit r_lock, r_err;

  dcache_port_arb #(.NREQ(2), .DEPTH(4), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wstrb_i(wstrb), .wdata_i(wdata), .addr_ok_o(addr_ok), .data_ok_o(data_ok),
    .rdata_o(rdata), .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr),
    .m_wstrb_o(m_wstrb), .m_wdata_o(m_wdata), .m_addr_ok_i(m_addr_ok),
    .m_data_ok_i(m_data_ok), .m_rdata_i(m_rdata), .outstanding_o(outstanding),
    .err_unexp_o(err)
  );

  always #5 clk = ~clk;

  // A requester that was stalled by the dcache must keep its request up.
  logic [1:0] held = '0;
  always @(negedge clk) begin
    if (!reset && (held & ~req) != 2'b00) begin
      n_fail++;
      $display("FAIL req_hold: held=%b req=%b", held, req);
    end
    held = (!reset && m_req && !m_addr_ok) ? req : 2'b00;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick();
    reset = 1'b0;
    r_q.delete(); r_rr = 0; r_lid = 0; r_lock = 0; r_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_mreq got=%b exp=0", m_req); end
    n_tests++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL rst_addr_ok got=%b exp=00", addr_ok); end
    n_tests++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL rst_data_ok got=%b exp=00", data_ok); end
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outst got=%0d exp=0", outstanding); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
  endtask

  task automatic test_single();
    do_reset();
    addr = {A1, A0}; req = 2'b01; m_addr_ok = 1'b1; #1;
    n_tests++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL single_addr_ok got=%b exp=01", addr_ok); end
    n_tests++; if (m_addr !== A0) begin n_fail++; $display("FAIL single_maddr got=%h exp=%h", m_addr, A0); end
    tick();
    req = 2'b00; m_addr_ok = 1'b0; #1;
    n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_outst1 got=%0d exp=1", outstanding); end
    tick(); tick();
    m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    n_tests++; if (data_ok !== 2'b01) begin n_fail++; $display("FAIL single_data_ok got=%b exp=01", data_ok); end
    n_tests++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
    tick();
    m_data_ok = 1'b0; #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_outst0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    do_reset();
    req = 2'b11; m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10; #1;
      n_tests++; if (addr_ok !== exp) begin n_fail++; $display("FAIL alt_grant%0d got=%b exp=%b", i, addr_ok, exp); end
      tick();
    end
    req = 2'b00; m_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      m_data_ok = 1'b1; m_rdata = 32'h100 + i; #1;
      n_tests++; if (data_ok !== exp) begin n_fail++; $display("FAIL alt_resp%0d got=%b exp=%b", i, data_ok, exp); end
      tick();
    end
    m_data_ok = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    addr = {A1, A0};
    req = 2'b01; m_addr_ok = 1'b1; tick();      // rr_ptr now points at requester 1
    req = 2'b01; m_addr_ok = 1'b0; #1;           // stall: grant of 0 gets locked
    n_tests++; if (m_addr !== A0) begin n_fail++; $display("FAIL lock_c0 got=%h exp=%h", m_addr, A0); end
    tick();
    req = 2'b11; #1;                             // requester 1 now has rr priority
    n_tests++; if (m_addr !== A0) begin n_fail++; $display("FAIL lock_c1 got=%h exp=%h", m_addr, A0); end
    n_tests++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL lock_c1_ok got=%b exp=00", addr_ok); end
    tick();
    m_addr_ok = 1'b1; #1;
    n_tests++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL lock_acc got=%b exp=01", addr_ok); end
    tick();
    req = 2'b10; #1;
    n_tests++; if (addr_ok !== 2'b10 || m_addr !== A1) begin n_fail++; $display("FAIL lock_next got=%b/%h exp=10/%h", addr_ok, m_addr, A1); end
    tick();
    req = 2'b00; m_addr_ok = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    req = 2'b11; m_addr_ok = 1'b1;
    repeat (4) tick();
    #1;
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outst got=%0d exp=4", outstanding); end
    n_tests++; if (m_req !== 1'b0 || addr_ok !== 2'b00) begin n_fail++; $display("FAIL full_block got=%b/%b exp=0/00", m_req, addr_ok); end
    m_data_ok = 1'b1; #1;
    n_tests++; if (data_ok !== 2'b01 || m_req !== 1'b0) begin n_fail++; $display("FAIL full_pop got=%b/%b exp=01/0", data_ok, m_req); end
    tick();
    m_data_ok = 1'b0; #1;
    n_tests++; if (m_req !== 1'b1 || outstanding !== 3'd3) begin n_fail++; $display("FAIL full_reopen got=%b/%0d exp=1/3", m_req, outstanding); end
    n_tests++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL full_regrant got=%b exp=01", addr_ok); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b01; m_addr_ok = 1'b1; tick();
    req = 2'b10; tick();
    req = 2'b01; m_data_ok = 1'b1; #1;
    n_tests++; if (addr_ok !== 2'b01 || data_ok !== 2'b01) begin n_fail++; $display("FAIL b2b_both got=%b/%b exp=01/01", addr_ok, data_ok); end
    tick();
    req = 2'b00; m_addr_ok = 1'b0; #1;
    n_tests++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_outst got=%0d exp=2", outstanding); end
    n_tests++; if (data_ok !== 2'b10) begin n_fail++; $display("FAIL b2b_id1 got=%b exp=10", data_ok); end
    tick(); #1;
    n_tests++; if (data_ok !== 2'b01) begin n_fail++; $display("FAIL b2b_id2 got=%b exp=01", data_ok); end
    tick();
    m_data_ok = 1'b0; #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got=%0d exp=0", outstanding); end
  endtask

  task automatic test_unexp_and_reset();
    do_reset();
    m_data_ok = 1'b1; #1;
    n_tests++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL unexp_data_ok got=%b exp=00", data_ok); end
    tick();
    m_data_ok = 1'b0; tick();
    n_tests++; if (err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL unexp_err got=%b/%0d exp=1/0", err, outstanding); end
    req = 2'b11; m_addr_ok = 1'b1;
    repeat (3) tick();
    req = 2'b00; m_addr_ok = 1'b0; #1;
    n_tests++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL mid_outst got=%0d exp=3", outstanding); end
    do_reset(); #1;
    n_tests++; if (outstanding !== 3'd0 || m_req !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", outstanding, m_req, err); end
    m_data_ok = 1'b1; tick();
    m_data_ok = 1'b0; #1;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err got=%b exp=1", err); end
  endtask

  function automatic int ref_gnt(input logic [1:0] r);
    int idx;
    if (r_lock) return r_lid;
    for (int k = 0; k < NREQ; k++) begin
      idx = (r_rr + k) % NREQ;
      if (((r >> idx) & 2'b01) != 2'b00) return idx;
    end
    return 0;
  endfunction

  task automatic test_random();
    logic [1:0] pend, e_aok, e_dok;
    bit e_mreq, acc, pp;
    int g;
    do_reset();
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        req[i] = pend[i] ? 1'b1 : ($urandom_range(0, 3) == 0);
      we = 2'($urandom); wstrb = 8'($urandom);
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      m_addr_ok = ($urandom_range(0, 9) < 6);
      m_data_ok = ($urandom_range(0, 9) < 4);
      m_rdata = $urandom;
      #1;
      g = ref_gnt(req);
      e_mreq = (req != 2'b00) && (r_q.size() < 4);
      acc = e_mreq && m_addr_ok;
      pp = m_data_ok && (r_q.size() > 0);
      e_aok = acc ? 2'(1 << g) : 2'b00;
      e_dok = pp ? 2'(1 << r_q[0]) : 2'b00;
      n_tests++; if (m_req !== e_mreq) begin n_fail++; $display("FAIL rnd_mreq c=%0d got=%b exp=%b", c, m_req, e_mreq); end
      n_tests++; if (addr_ok !== e_aok) begin n_fail++; $display("FAIL rnd_addr_ok c=%0d got=%b exp=%b", c, addr_ok, e_aok); end
      n_tests++; if (data_ok !== e_dok) begin n_fail++; $display("FAIL rnd_data_ok c=%0d got=%b exp=%b", c, data_ok, e_dok); end
      n_tests++; if (outstanding !== 3'(r_q.size())) begin n_fail++; $display("FAIL rnd_outst c=%0d got=%0d exp=%0d", c, outstanding, r_q.size()); end
      n_tests++; if (err !== r_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, r_err); end
      if (e_mreq) begin
        n_tests++;
        if (m_addr !== 32'(addr >> (g*32)) || m_wdata !== 32'(wdata >> (g*32)) ||
            m_wstrb !== 4'(wstrb >> (g*4)) || m_we !== we[g]) begin
          n_fail++; $display("FAIL rnd_fields c=%0d g=%0d got=%h/%h/%h/%b", c, g, m_addr, m_wdata, m_wstrb, m_we);
        end
      end
      if (pp) begin
        n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
      end
      pend = req & ~e_aok;
      @(posedge clk);
      if (m_data_ok && r_q.size() == 0) r_err = 1;
      if (pp) void'(r_q.pop_front());
      if (acc) begin
        r_q.push_back(g); r_rr = (g + 1) % NREQ; r_lock = 0;
      end else if (e_mreq) begin
        r_lock = 1; r_lid = g;
      end
      #1;
    end
    req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_full();
    test_back_to_back();
    test_unexp_and_reset();
    test_random();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
